pot_scan_ctrl: RTL and testbench

//  Sequencer for POKEY potentiometer (paddle) scan. On a POTGO write it dumps the pot

---
 rtl/pot_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_pot_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pot_scan_ctrl.sv
// POKEY pot scan sequencer: dumps the pot capacitors on POTGO, counts scan lines, latches each
// pot's count and keeps ALLPOT. Optional feature macro: FAST_SCAN_EN (per-o2 count, no dump).
module pot_scan_ctrl #(
  parameter int unsigned NUM_POTS    = 8,
  parameter int unsigned MAX_COUNT   = 228,
  parameter int unsigned DUMP_CYCLES = 4
) (
  input  logic                o2,
  input  logic                rst,
  input  logic                line_strobe,
  input  logic                potgo_wr,
  input  logic                fast_scan,
  input  logic [NUM_POTS-1:0] pot_in,
  input  logic [3:0]          rd_addr,
  output logic [7:0]          data_out,
  output logic [NUM_POTS-1:0] pot_dump,
  output logic                scan_busy,
  output logic                scan_done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDump = 2'd1,
    StScan = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned     DumpW    = (DUMP_CYCLES > 1) ? $clog2(DUMP_CYCLES) : 1;
  localparam logic [DumpW-1:0] DumpLast = DumpW'(DUMP_CYCLES - 1);
  localparam logic [7:0]      MaxCnt   = 8'(MAX_COUNT);
  localparam logic [7:0]      MaxCntM1 = 8'(MAX_COUNT - 1);

  state_e                     state_q, state_d;
  logic [DumpW-1:0]           dump_cnt_q, dump_cnt_d;
  logic [7:0]                 count_q, count_d;
  logic [NUM_POTS-1:0][7:0]   pot_q, pot_d;
  logic [NUM_POTS-1:0]        allpot_q, allpot_d;
  logic                       scan_done_q, scan_done_d;
  logic                       count_en;
  logic                       go_scan;

`ifdef FAST_SCAN_EN
  logic fast_q, fast_d;
  // fast mode is frozen at POTGO; a fast scan relies on external dump and skips DUMP
  assign count_en = line_strobe | fast_q;
  assign go_scan  = fast_scan;
`else
  logic unused_fast_scan;
  assign unused_fast_scan = fast_scan;
  assign count_en         = line_strobe;
  assign go_scan          = 1'b0;
`endif

  always_ff @(posedge o2 or posedge rst) begin
    if (rst) begin
      state_q     <= StDone;
      dump_cnt_q  <= '0;
      count_q     <= '0;
      pot_q       <= '0;
      allpot_q    <= '0;
      scan_done_q <= 1'b0;
`ifdef FAST_SCAN_EN
      fast_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dump_cnt_q  <= dump_cnt_d;
      count_q     <= count_d;
      pot_q       <= pot_d;
      allpot_q    <= allpot_d;
      scan_done_q <= scan_done_d;
`ifdef FAST_SCAN_EN
      fast_q      <= fast_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    dump_cnt_d  = dump_cnt_q;
    count_d     = count_q;
    pot_d       = pot_q;
    allpot_d    = allpot_q;
    scan_done_d = 1'b0;
`ifdef FAST_SCAN_EN
    fast_d      = fast_q;
`endif
    if (potgo_wr) begin
      state_d    = go_scan ? StScan : StDump;
      dump_cnt_d = '0;
      count_d    = '0;
      pot_d      = '0;
      allpot_d   = '1;
`ifdef FAST_SCAN_EN
      fast_d     = fast_scan;
`endif
    end else begin
      case (state_q)
        StDump: begin
          if (dump_cnt_q == DumpLast) begin
            state_d = StScan;
            count_d = '0;
          end else begin
            dump_cnt_d = DumpW'(dump_cnt_q + 1'b1);
          end
        end
        StScan: begin
          // latches take the pre-increment count, even on the terminal cycle
          for (int i = 0; i < NUM_POTS; i++) begin
            if (allpot_q[i] && pot_in[i]) begin
              pot_d[i]    = count_q;
              allpot_d[i] = 1'b0;
            end
          end
          if (count_en) begin
            if (count_q >= MaxCntM1) begin
              count_d     = MaxCnt;
              state_d     = StDone;
              scan_done_d = 1'b1;
              for (int i = 0; i < NUM_POTS; i++) begin
                if (allpot_q[i] && !pot_in[i]) begin
                  pot_d[i] = MaxCnt;
                end
              end
              allpot_d = '0;
            end else begin
              count_d = 8'(count_q + 8'd1);
            end
          end
        end
        StDone: ;
        default: state_d = StDone;
      endcase
    end
  end

  always_comb begin
    logic [7:0] allpot_ext;
    allpot_ext                 = '0;
    allpot_ext[NUM_POTS-1:0]   = allpot_q;
    data_out                   = '0;
    if (rd_addr == 4'd8) begin
      data_out = allpot_ext;
    end else begin
      for (int i = 0; i < NUM_POTS; i++) begin
        if (rd_addr == 4'(i)) begin
          data_out = pot_q[i];
        end
      end
    end
  end

  assign scan_busy = (state_q == StDump) || (state_q == StScan);
  assign pot_dump  = (state_q == StScan) ? '0 : '1;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// Randomized bench for pot_scan_ctrl against a strobe-counting reference model.
// Build with FAST_SCAN_EN defined to exercise the fast-scan variant.
module tb_pot_scan_ctrl;
  localparam int unsigned NUM_POTS    = 8;
  localparam int unsigned MAX_COUNT   = 228;
  localparam int unsigned DUMP_CYCLES = 4;

  logic                o2 = 1'b0;
  logic                rst;
  logic                line_strobe;
  logic                potgo_wr;
  logic                fast_scan;
  logic [NUM_POTS-1:0] pot_in;
  logic [3:0]          rd_addr;
  logic [7:0]          data_out;
  logic [NUM_POTS-1:0] pot_dump;
  logic                scan_busy;
  logic                scan_done;

  pot_scan_ctrl #(
    .NUM_POTS   (NUM_POTS),
    .MAX_COUNT  (MAX_COUNT),
    .DUMP_CYCLES(DUMP_CYCLES)
  ) dut (
    .o2         (o2),
    .rst        (rst),
    .line_strobe(line_strobe),
    .potgo_wr   (potgo_wr),
    .fast_scan  (fast_scan),
    .pot_in     (pot_in),
    .rd_addr    (rd_addr),
    .data_out   (data_out),
    .pot_dump   (pot_dump),
    .scan_busy  (scan_busy),
    .scan_done  (scan_done)
  );

  always #10 o2 = ~o2;

  int n_vec = 0;
  int n_err = 0;

  // reference model: scan progress measured in cycles since POTGO and strobes seen in SCAN
  bit               m_active = 1'b0;
  bit               m_fast   = 1'b0;
  bit               m_done   = 1'b0;
  int               m_since  = 0;
  int               m_strobes = 0;
  bit [NUM_POTS-1:0] m_pend  = '0;
  int               m_pot [NUM_POTS];
  int               rise  [NUM_POTS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_scanning();
    return m_active && (m_since >= DUMP_CYCLES);
  endfunction

  function automatic int exp_read(input int a);
    if (a < NUM_POTS) return m_pot[a];
    if (a == 8) return int'(m_pend);
    return 0;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_fast = 1'b0; m_done = 1'b0;
    m_since = 0; m_strobes = 0; m_pend = '0;
    for (int i = 0; i < NUM_POTS; i++) m_pot[i] = 0;
  endtask

  task automatic model_cycle(input bit go, input bit strb, input bit fst,
                             input bit [NUM_POTS-1:0] pin);
    m_done = 1'b0;
    if (go) begin
      m_active = 1'b1; m_since = 0; m_strobes = 0; m_pend = '1;
      for (int i = 0; i < NUM_POTS; i++) m_pot[i] = 0;
`ifdef FAST_SCAN_EN
      m_fast = fst;
      if (fst) m_since = DUMP_CYCLES;
`else
      m_fast = 1'b0;
      if (fst) m_fast = 1'b0;
`endif
    end else if (m_active) begin
      if (m_since < DUMP_CYCLES) begin
        m_since++;
      end else begin
        for (int i = 0; i < NUM_POTS; i++)
          if (m_pend[i] && pin[i]) begin
            m_pot[i] = m_strobes;
            m_pend[i] = 1'b0;
          end
        if (strb || m_fast) begin
          m_strobes++;
          if (m_strobes == MAX_COUNT) begin
            for (int i = 0; i < NUM_POTS; i++) if (m_pend[i]) m_pot[i] = MAX_COUNT;
            m_pend = '0; m_active = 1'b0; m_done = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [NUM_POTS-1:0] pot_pattern();
    logic [NUM_POTS-1:0] p;
    for (int i = 0; i < NUM_POTS; i++)
      p[i] = m_pend[i] ? (rise[i] <= m_strobes) : 1'($urandom % 2);
    return p;
  endfunction

  task automatic step(input bit go, input bit strb, input logic [NUM_POTS-1:0] pin);
    potgo_wr    = go;
    line_strobe = strb;
    pot_in      = pin;
    fast_scan   = 1'($urandom % 2);
    rd_addr     = 4'($urandom % 16);
    @(posedge o2);
    model_cycle(go, strb, fast_scan, pin);
    #1;
    check_eq("scan_busy", 32'(scan_busy), 32'(m_active));
    check_eq("pot_dump", 32'(pot_dump), m_scanning() ? 32'd0 : 32'((1 << NUM_POTS) - 1));
    check_eq("scan_done", 32'(scan_done), 32'(m_done));
    check_eq("data_out", 32'(data_out), 32'(exp_read(int'(rd_addr))));
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      check_eq(tag, 32'(data_out), 32'(exp_read(a)));
    end
  endtask

  initial begin
    logic [NUM_POTS-1:0] pins;
    bit go, strb, did_reset, did_int;
    int n;
    model_reset();
    rst = 1'b1; potgo_wr = 1'b0; line_strobe = 1'b0; fast_scan = 1'b0;
    pot_in = '0; rd_addr = '0;
    #3;
    check_eq("rst_busy", 32'(scan_busy), 32'd0);
    check_eq("rst_dump", 32'(pot_dump), 32'((1 << NUM_POTS) - 1));
    check_eq("rst_done", 32'(scan_done), 32'd0);
    read_all("rst_read");
    rst = 1'b0;
    did_reset = 1'b0;

    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < NUM_POTS; i++) rise[i] = $urandom_range(0, 260);
      rise[s % NUM_POTS]       = 0;
      rise[(s + 3) % NUM_POTS] = MAX_COUNT - 1;
      rise[(s + 5) % NUM_POTS] = 1000;
      pins = pot_pattern();
      step(1'b1, 1'b0, pins);
      did_int = 1'b0;
      n = 0;
      while (m_active && n < 3000) begin
        pins = pot_pattern();
        strb = 1'($urandom % 2);
        go   = 1'b0;
        if (s == 0 && !did_reset && m_scanning() && m_strobes == 50) begin
          did_reset = 1'b1;
          #3 rst = 1'b1;
          #1 model_reset();
          check_eq("async_busy", 32'(scan_busy), 32'd0);
          check_eq("async_dump", 32'(pot_dump), 32'((1 << NUM_POTS) - 1));
          check_eq("async_done", 32'(scan_done), 32'd0);
          check_eq("async_read", 32'(data_out), 32'(exp_read(int'(rd_addr))));
          #2 rst = 1'b0;
          break;
        end
        if (!did_int) begin
          if (s == 1 && m_scanning() && m_strobes == 120) go = 1'b1;
          if (s == 2 && m_active && m_since == 2) go = 1'b1;
          if (s == 4 && m_scanning() && ((pins & m_pend) != '0)) go = 1'b1;
          if (go) did_int = 1'b1;
        end
        step(go, strb, pins);
        n++;
      end
      check_eq("scan_end", 32'(scan_busy), 32'd0);
      read_all("final_read");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
